// File: rtl/reu_dma_engine.sv
// Transfer sequencer for the REU: stash, fetch, swap and verify between C64 memory and REU RAM.
// One C64 access (toggle handshake) or one RAM access (level request) is outstanding at a time.
module reu_dma_engine #(
    parameter int REU_ADDR_BITS = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               cfg_mode,
    input  logic [15:0]              cfg_c64_addr,
    input  logic [REU_ADDR_BITS-1:0] cfg_reu_addr,
    input  logic [15:0]              cfg_len,
    input  logic                     cfg_fix_c64,
    input  logic                     cfg_fix_reu,
    output logic                     busy,
    output logic                     done,
    output logic                     verify_error,
    output logic [15:0]              cur_c64_addr,
    output logic [REU_ADDR_BITS-1:0] cur_reu_addr,
    output logic [15:0]              cur_len,
    output logic [15:0]              dma_a,
    output logic [7:0]               dma_d,
    output logic                     dma_rw,
    output logic                     dma_req,
    input  logic                     dma_ack,
    input  logic [7:0]               dma_q,
    output logic [REU_ADDR_BITS-1:0] ram_addr,
    output logic [7:0]               ram_wdata,
    output logic                     ram_we,
    output logic                     ram_req,
    input  logic                     ram_ack,
    input  logic [7:0]               ram_rdata
);
    typedef enum logic [2:0] {
        IDLE, C64_RD, RAM_RD, C64_WR, RAM_WR, CHECK, ADVANCE, FINISH
    } state_t;

    localparam logic [1:0] MODE_STASH  = 2'b00;
    localparam logic [1:0] MODE_FETCH  = 2'b01;
    localparam logic [1:0] MODE_SWAP   = 2'b10;
    localparam logic [1:0] MODE_VERIFY = 2'b11;
    localparam logic [REU_ADDR_BITS-1:0] REU_ONE = {{(REU_ADDR_BITS-1){1'b0}}, 1'b1};

    state_t                   state_reg, state_next, first_state;
    logic [1:0]               mode_reg, mode_eff;
    logic                     fix_c64_reg, fix_reu_reg;
    logic [15:0]              c64_addr_reg, c64_addr_next;
    logic [REU_ADDR_BITS-1:0] reu_addr_reg, reu_addr_next;
    logic [15:0]              len_reg, len_next;
    logic [7:0]               c64_byte_reg, reu_byte_reg;
    logic                     verify_error_reg, done_reg;
    logic                     dma_req_reg, dma_rw_reg;
    logic [15:0]              dma_a_reg;
    logic [7:0]               dma_d_reg;
    logic                     ram_req_reg, ram_we_reg;
    logic [REU_ADDR_BITS-1:0] ram_addr_reg;
    logic [7:0]               ram_wdata_reg;
    logic                     c64_done, accept, mismatch, issue_c64, issue_ram;

    always_comb begin
        mode_eff      = (state_reg == IDLE) ? cfg_mode : mode_reg;
        first_state   = (mode_eff == MODE_FETCH) ? RAM_RD : C64_RD;
        c64_done      = (dma_req_reg == dma_ack);
        accept        = 1'b0;
        mismatch      = 1'b0;
        state_next    = state_reg;
        c64_addr_next = c64_addr_reg;
        reu_addr_next = reu_addr_reg;
        len_next      = len_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept        = 1'b1;
                    state_next    = first_state;
                    c64_addr_next = cfg_c64_addr;
                    reu_addr_next = cfg_reu_addr;
                    len_next      = cfg_len;
                end
            end
            C64_RD:  if (c64_done) state_next = (mode_reg == MODE_STASH) ? RAM_WR : RAM_RD;
            RAM_RD:  if (ram_ack) state_next = (mode_reg == MODE_VERIFY) ? CHECK : C64_WR;
            C64_WR:  if (c64_done) state_next = (mode_reg == MODE_SWAP) ? RAM_WR : ADVANCE;
            RAM_WR:  if (ram_ack) state_next = ADVANCE;
            CHECK: begin
                mismatch   = (c64_byte_reg != reu_byte_reg);
                state_next = ADVANCE;
            end
            ADVANCE: begin
                // The last byte and an aborted verify both leave the counters untouched.
                if (len_reg == 16'd1 || verify_error_reg) begin
                    state_next = FINISH;
                end else begin
                    state_next = first_state;
                    len_next   = len_reg - 16'd1;
                    if (!fix_c64_reg) c64_addr_next = c64_addr_reg + 16'd1;
                    if (!fix_reu_reg) reu_addr_next = reu_addr_reg + REU_ONE;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Accesses are launched on entry, so the request appears with the state itself.
        issue_c64 = (state_next == C64_RD || state_next == C64_WR) && (state_next != state_reg);
        issue_ram = (state_next == RAM_RD || state_next == RAM_WR) && (state_next != state_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            mode_reg         <= MODE_STASH;
            fix_c64_reg      <= 1'b0;
            fix_reu_reg      <= 1'b0;
            c64_addr_reg     <= '0;
            reu_addr_reg     <= '0;
            len_reg          <= '0;
            c64_byte_reg     <= '0;
            reu_byte_reg     <= '0;
            verify_error_reg <= 1'b0;
            done_reg         <= 1'b0;
            dma_req_reg      <= dma_ack;
            dma_rw_reg       <= 1'b1;
            dma_a_reg        <= '0;
            dma_d_reg        <= '0;
            ram_req_reg      <= 1'b0;
            ram_we_reg       <= 1'b0;
            ram_addr_reg     <= '0;
            ram_wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            c64_addr_reg <= c64_addr_next;
            reu_addr_reg <= reu_addr_next;
            len_reg      <= len_next;
            done_reg     <= (state_reg == FINISH);
            if (accept) begin
                mode_reg         <= cfg_mode;
                fix_c64_reg      <= cfg_fix_c64;
                fix_reu_reg      <= cfg_fix_reu;
                verify_error_reg <= 1'b0;
            end else if (mismatch) begin
                verify_error_reg <= 1'b1;
            end
            if (state_reg == C64_RD && c64_done) c64_byte_reg <= dma_q;
            if (state_reg == RAM_RD && ram_ack) reu_byte_reg <= ram_rdata;
            // Bytes read in the completing cycle are forwarded straight to the next access.
            if (issue_c64) begin
                dma_req_reg <= ~dma_req_reg;
                dma_a_reg   <= c64_addr_next;
                dma_rw_reg  <= (state_next == C64_RD);
                dma_d_reg   <= (state_reg == RAM_RD) ? ram_rdata : reu_byte_reg;
            end
            if (issue_ram) begin
                ram_req_reg   <= 1'b1;
                ram_addr_reg  <= reu_addr_next;
                ram_we_reg    <= (state_next == RAM_WR);
                ram_wdata_reg <= (state_reg == C64_RD) ? dma_q : c64_byte_reg;
            end else if (ram_ack && (state_reg == RAM_RD || state_reg == RAM_WR)) begin
                ram_req_reg <= 1'b0;
            end
        end
    end

    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign verify_error = verify_error_reg;
    assign cur_c64_addr = c64_addr_reg;
    assign cur_reu_addr = reu_addr_reg;
    assign cur_len      = len_reg;
    assign dma_a        = dma_a_reg;
    assign dma_d        = dma_d_reg;
    assign dma_rw       = dma_rw_reg;
    assign dma_req      = dma_req_reg;
    assign ram_addr     = ram_addr_reg;
    assign ram_wdata    = ram_wdata_reg;
    assign ram_we       = ram_we_reg;
    assign ram_req      = ram_req_reg;

endmodule
